cfi_log_queue: RTL and testbench



---
 rtl/cfi_pkg.sv | 40 ++++
 rtl/cfi_log_queue_if.sv | 37 +++
 rtl/cfi_log_encode.sv | 23 ++
 rtl/cfi_log_queue.sv | 101 ++++++++++
 tb/tb_cfi_log_queue.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cfi_pkg.sv
// cfi_pkg: shared types and constants for the CFI logging path.
//   cfi_kind_t  - 3-bit control-flow kind of a retiring instruction
//   cfi_log_t   - queued record {pc, target, flags[3:0]}
//   CFI_FLAGS_* - flag nibble stored for each legal kind
package cfi_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    CFI_NONE   = 3'd0,
    CFI_BRANCH = 3'd1,
    CFI_JUMP   = 3'd2,
    CFI_CALL   = 3'd3,
    CFI_RETURN = 3'd4
  } cfi_kind_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic [3:0]      flags;
  } cfi_log_t;

  localparam logic [3:0] CFI_FLAGS_BRANCH = 4'b1000;
  localparam logic [3:0] CFI_FLAGS_JUMP   = 4'b0100;
  localparam logic [3:0] CFI_FLAGS_CALL   = 4'b0110;
  localparam logic [3:0] CFI_FLAGS_RETURN = 4'b0101;

  // Flag nibble for a kind; zero means "not a loggable control-flow op",
  // which also covers the illegal encodings 5..7.
  function automatic logic [3:0] kind_to_flags(cfi_kind_t kind);
    case (kind)
      CFI_BRANCH: return CFI_FLAGS_BRANCH;
      CFI_JUMP:   return CFI_FLAGS_JUMP;
      CFI_CALL:   return CFI_FLAGS_CALL;
      CFI_RETURN: return CFI_FLAGS_RETURN;
      default:    return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/cfi_log_queue_if.sv
// cfi_log_queue_if: commit-side and drain-side signals of the CFI log queue.
//   enable        - logging enable
//   commit_*      - per-port retire bundle, commit_ready back-pressure
//   log           - head record (zero when empty)
//   queue_empty   - no record available
//   queue_pop     - consumer takes head record
//   usage         - current occupancy
// master: commit stage + backend; slave: the queue.
interface cfi_log_queue_if
  import cfi_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int NR_PORTS = 2
) ();

  logic                                enable;
  logic      [NR_PORTS-1:0]            commit_valid;
  cfi_kind_t [NR_PORTS-1:0]            commit_kind;
  logic      [NR_PORTS-1:0][XLEN-1:0]  commit_pc;
  logic      [NR_PORTS-1:0][XLEN-1:0]  commit_target;
  logic                                commit_ready;
  cfi_log_t                            log;
  logic                                queue_empty;
  logic                                queue_pop;
  logic      [$clog2(DEPTH+1)-1:0]     usage;

  modport master (
    output enable, commit_valid, commit_kind, commit_pc, commit_target, queue_pop,
    input  commit_ready, log, queue_empty, usage
  );

  modport slave (
    input  enable, commit_valid, commit_kind, commit_pc, commit_target, queue_pop,
    output commit_ready, log, queue_empty, usage
  );

endinterface

// File: rtl/cfi_log_encode.sv
// cfi_log_encode: per-port combinational encoder.
//   valid, kind, pc, target - retiring instruction on one commit port
//   push                    - port carries a loggable control-flow op
//   log                     - encoded record for the queue
module cfi_log_encode
  import cfi_pkg::*;
(
  input  logic            valid,
  input  cfi_kind_t       kind,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] target,
  output logic            push,
  output cfi_log_t        log
);

  always_comb begin
    log.pc     = pc;
    log.target = target;
    log.flags  = kind_to_flags(kind);
    push       = valid && (log.flags != 4'b0000);
  end

endmodule

// File: rtl/cfi_log_queue.sv
// cfi_log_queue: multi-write, single-read circular queue of CFI records.
//   clk_i - clock
//   rst_i - synchronous active-high reset
//   bus   - cfi_log_queue_if.slave (commit ports, enable, drain side)
// Up to NR_PORTS records enter per cycle, compacted in port order at the
// tail; one record leaves per cycle. All outputs come from registered state.
module cfi_log_queue
  import cfi_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int NR_PORTS = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  cfi_log_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - NR_PORTS);

  cfi_log_t             mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]     usage_reg, usage_next;

  logic [NR_PORTS-1:0]  enc_push;
  cfi_log_t             enc_log [NR_PORTS];
  logic [NR_PORTS-1:0]  push_mask;
  logic [PTR_W-1:0]     slot_ptr [NR_PORTS];
  logic [CNT_W-1:0]     push_cnt;
  logic                 ready;
  logic                 empty;
  logic                 pop_en;

  generate
    for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_enc
      cfi_log_encode u_enc (
        .valid  (bus.commit_valid[gi]),
        .kind   (bus.commit_kind[gi]),
        .pc     (bus.commit_pc[gi]),
        .target (bus.commit_target[gi]),
        .push   (enc_push[gi]),
        .log    (enc_log[gi])
      );
    end
  endgenerate

  // Ready is judged on the registered count alone so there is no path
  // from queue_pop to commit_ready.
  assign ready     = (usage_reg <= READY_MAX);
  assign empty     = (usage_reg == '0);
  assign pop_en    = bus.queue_pop && !empty;
  assign push_mask = enc_push & {NR_PORTS{bus.enable && ready}};

  // Compaction: each pushing port lands at tail + (number of older pushing
  // ports), so the group occupies consecutive slots without holes.
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      slot_ptr[p] = wr_ptr_reg + acc[PTR_W-1:0];
      acc         = acc + CNT_W'(push_mask[p]);
    end
    push_cnt = acc;
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg + push_cnt[PTR_W-1:0];
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop_en);
    usage_next  = usage_reg + push_cnt - CNT_W'(pop_en);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      usage_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      usage_reg  <= usage_next;
    end
  end

  // Storage is not reset; stale slots are never visible because the
  // count gates the head output.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NR_PORTS; p++) begin
      if (push_mask[p]) begin
        mem[slot_ptr[p]] <= enc_log[p];
      end
    end
  end

  assign bus.commit_ready = ready;
  assign bus.queue_empty  = empty;
  assign bus.usage        = usage_reg;
  assign bus.log          = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: tb/tb_cfi_log_queue.sv
// tb_cfi_log_queue: randomized scoreboard bench for cfi_log_queue.
// The driver decides, from a simple occupancy count, which records the
// queue must accept and appends them to an expected queue; a negedge
// monitor checks status outputs and compares every popped head record.
module tb_cfi_log_queue;
  import cfi_pkg::*;

  localparam int DEPTH    = 8;
  localparam int NR_PORTS = 2;

  logic clk;
  logic rst;

  cfi_log_queue_if #(.DEPTH(DEPTH), .NR_PORTS(NR_PORTS)) bus ();

  cfi_log_queue #(.DEPTH(DEPTH), .NR_PORTS(NR_PORTS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cfi_log_t exp_q[$];
  int       model_usage = 0;
  int       chk_usage   = 0;
  bit       chk_en      = 1'b0;
  int       n_checks    = 0;
  int       n_pass      = 0;
  int       n_pops      = 0;

  function automatic logic [3:0] flags_of(int k);
    case (k)
      1:       return 4'b1000;
      2:       return 4'b0100;
      3:       return 4'b0110;
      4:       return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // One clock cycle of stimulus; returns at posedge+1.
  task automatic cycle(input logic rst_v, input logic en, input logic [1:0] v,
                       input int k0, input int k1,
                       input logic [31:0] pc0, input logic [31:0] t0,
                       input logic [31:0] pc1, input logic [31:0] t1,
                       input logic pop);
    int       pushes;
    bit       ready_m;
    int       k;
    cfi_log_t rec;
    rst                   = rst_v;
    bus.enable            = en;
    bus.commit_valid      = v;
    bus.commit_kind[0]    = cfi_kind_t'(k0[2:0]);
    bus.commit_kind[1]    = cfi_kind_t'(k1[2:0]);
    bus.commit_pc[0]      = pc0;
    bus.commit_target[0]  = t0;
    bus.commit_pc[1]      = pc1;
    bus.commit_target[1]  = t1;
    bus.queue_pop         = pop;
    chk_usage             = model_usage;
    if (rst_v) begin
      exp_q.delete();
      model_usage = 0;
    end else begin
      pushes  = 0;
      ready_m = (model_usage <= DEPTH - NR_PORTS);
      for (int p = 0; p < NR_PORTS; p++) begin
        k = (p == 0) ? k0 : k1;
        if (en && v[p] && flags_of(k) != 4'b0000 && ready_m) begin
          rec.pc     = (p == 0) ? pc0 : pc1;
          rec.target = (p == 0) ? t0 : t1;
          rec.flags  = flags_of(k);
          exp_q.push_back(rec);
          pushes++;
        end
      end
      if (pop && model_usage > 0) model_usage--;
      model_usage += pushes;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic pop);
    cycle(1'b0, 1'b1, 2'b00, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, pop);
  endtask

  task automatic rnd_push(input logic [1:0] v, input logic pop);
    cycle(1'b0, 1'b1, v, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
          $urandom, $urandom, $urandom, $urandom, pop);
  endtask

  // Monitor: status every cycle, head record on every accepted pop.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("usage", bus.usage, chk_usage);
      chk("commit_ready", bus.commit_ready, chk_usage <= DEPTH - NR_PORTS);
      chk("queue_empty", bus.queue_empty, chk_usage == 0);
      if (bus.queue_empty) begin
        chk("log_zero", bus.log, '0);
      end else if (bus.queue_pop && !rst) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 1'b1, 1'b0);
        end else begin
          cfi_log_t e;
          e = exp_q.pop_front();
          n_pops++;
          $display("pop %0d: pc=%08h target=%08h flags=%04b exp_flags=%04b",
                   n_pops, bus.log.pc, bus.log.target, bus.log.flags, e.flags);
          chk("log_record", bus.log, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.commit_valid = '0;
    bus.commit_kind[0] = CFI_NONE;
    bus.commit_kind[1] = CFI_NONE;
    bus.commit_pc = '0;
    bus.commit_target = '0;
    bus.queue_pop = 1'b0;

    cycle(1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    cycle(1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    chk_en = 1'b1;
    idle(1'b0);

    // CALL + RETURN in one cycle, then pop both
    cycle(1'b0, 1'b1, 2'b11, 3, 4, 32'h100, 32'h200, 32'h204, 32'h104, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // port0 NONE, port1 BRANCH: single record, no hole
    cycle(1'b0, 1'b1, 2'b11, 0, 1, 32'h300, 32'h304, 32'h310, 32'h400, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // 3 records per 2 cycles until ready drops, then one pop restores it
    for (int i = 0; i < 8; i++) rnd_push((i % 2 == 0) ? 2'b01 : 2'b11, 1'b0);
    idle(1'b1);
    idle(1'b0);
    for (int i = 0; i < 10; i++) idle(1'b1);

    // fill 6, drain 5, push 6 more: pointers wrap
    for (int i = 0; i < 3; i++) rnd_push(2'b11, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    for (int i = 0; i < 3; i++) rnd_push(2'b11, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b1);

    // pop while empty, illegal kind, disabled logging
    idle(1'b1);
    cycle(1'b0, 1'b1, 2'b11, 7, 7, 32'h500, 32'h504, 32'h508, 32'h50c, 1'b0);
    cycle(1'b0, 1'b0, 2'b11, 3, 3, 32'h600, 32'h604, 32'h608, 32'h60c, 1'b0);
    idle(1'b0);

    // reset with 4 queued, while pushing and popping
    rnd_push(2'b11, 1'b0);
    rnd_push(2'b11, 1'b0);
    cycle(1'b1, 1'b1, 2'b11, 3, 4, 32'h700, 32'h704, 32'h708, 32'h70c, 1'b1);
    idle(1'b0);

    // randomized traffic with alternating pop pressure
    for (int i = 0; i < 400; i++) begin
      int pct;
      pct = ((i / 100) % 2 == 1) ? 80 : 30;
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
            2'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom, $urandom,
            ($urandom_range(0, 99) < pct));
    end

    for (int i = 0; i < 12; i++) idle(1'b1);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
